// File: rtl/fanin_event_collector_if.sv
// Event fan-in channel: N event pulse lines in, one indexed valid/ready
// stream out, plus status (busy, drop_cnt).
//   in        : N-bit event pulses (master -> collector)
//   out_valid : presented event is valid (collector -> master)
//   out_idx   : source index of presented event (collector -> master)
//   out_ready : consumer accepts presented event (master -> collector)
//   busy      : events pending or presented (collector -> master)
//   drop_cnt  : saturating count of merged events (collector -> master)
interface fanin_event_collector_if #(
  parameter int unsigned N    = 20,
  parameter int unsigned IDXW = 5,
  parameter int unsigned CNTW = 8
);
  logic [N-1:0]    in;
  logic            out_valid;
  logic [IDXW-1:0] out_idx;
  logic            out_ready;
  logic            busy;
  logic [CNTW-1:0] drop_cnt;

  modport master (
    output in, out_ready,
    input  out_valid, out_idx, busy, drop_cnt
  );

  modport slave (
    input  in, out_ready,
    output out_valid, out_idx, busy, drop_cnt
  );
endinterface

// File: rtl/fanin_event_collector.sv
// Collects single-cycle event pulses from N sources into per-source pending
// bits and serializes them round-robin onto one registered valid/ready stream.
// A second event on a source whose pending bit is still set (and not being
// granted) is merged and counted in a saturating drop counter.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   evt : event channel (slave side), see fanin_event_collector_if
module fanin_event_collector #(
  parameter int unsigned N    = 20,
  parameter int unsigned IDXW = 5,
  parameter int unsigned CNTW = 8
) (
  input logic                   clk,
  input logic                   rst,
  fanin_event_collector_if.slave evt
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned SW = CNTW + CW;

  logic [N-1:0]    r_pending;
  logic            r_out_valid;
  logic [IDXW-1:0] r_out_idx;
  logic [IDXW-1:0] r_ptr;
  logic [CNTW-1:0] r_drop_cnt;

  logic            w_slot_free;
  logic            w_found;
  logic [IDXW-1:0] w_grant_idx;
  logic [IDXW:0]   w_cand;
  logic            w_grant;
  logic [N-1:0]    w_grant_mask;
  logic [N-1:0]    w_merge;
  logic [CW-1:0]   w_nmerge;
  logic [SW-1:0]   w_sum;
  logic [CNTW-1:0] w_drop_next;

  assign w_slot_free = !r_out_valid || evt.out_ready;

  // Round-robin search starting just after ptr; ptr itself is visited last.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = r_ptr;
    w_cand      = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      w_cand = {1'b0, r_ptr} + (IDXW+1)'(off);
      if (w_cand >= (IDXW+1)'(N))
        w_cand = w_cand - (IDXW+1)'(N);
      if (!w_found && r_pending[w_cand[IDXW-1:0]]) begin
        w_found     = 1'b1;
        w_grant_idx = w_cand[IDXW-1:0];
      end
    end
  end

  assign w_grant = w_slot_free && w_found;

  always_comb begin
    w_grant_mask = '0;
    for (int unsigned i = 0; i < N; i++)
      w_grant_mask[i] = w_grant && (w_grant_idx == IDXW'(i));
  end

  // A source whose pending bit is being granted this edge can absorb a new
  // pulse without loss; only the remaining collisions are drops.
  assign w_merge = evt.in & r_pending & ~w_grant_mask;

  always_comb begin
    w_nmerge = '0;
    for (int unsigned i = 0; i < N; i++)
      w_nmerge = w_nmerge + CW'(w_merge[i]);
  end

  always_comb begin
    w_sum       = SW'(r_drop_cnt) + SW'(w_nmerge);
    w_drop_next = (w_sum > SW'({CNTW{1'b1}})) ? '1 : w_sum[CNTW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending   <= '0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_ptr       <= IDXW'(N - 1);
      r_drop_cnt  <= '0;
    end else begin
      r_pending  <= (r_pending & ~w_grant_mask) | evt.in;
      r_drop_cnt <= w_drop_next;
      if (w_slot_free) begin
        r_out_valid <= w_found;
        if (w_found) begin
          r_out_idx <= w_grant_idx;
          r_ptr     <= w_grant_idx;
        end
      end
    end
  end

  assign evt.out_valid = r_out_valid;
  assign evt.out_idx   = r_out_idx;
  assign evt.drop_cnt  = r_drop_cnt;
  assign evt.busy      = (|r_pending) || r_out_valid;

endmodule

// File: tb/tb_fanin_event_collector.sv
// Directed + randomized bench for fanin_event_collector with a cycle-level
// reference model built from the source/slot/pointer rules.
module tb_fanin_event_collector;

  localparam int N    = 20;
  localparam int IDXW = 5;
  localparam int CNTW = 8;
  localparam int DMAX = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fanin_event_collector_if #(.N(N), .IDXW(IDXW), .CNTW(CNTW)) bus ();

  fanin_event_collector #(.N(N), .IDXW(IDXW), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .evt (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit m_pend [N];
  bit m_ov;
  int m_oi;
  int m_ptr;
  int m_drop;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    m_ov = 1'b0; m_oi = 0; m_ptr = N - 1; m_drop = 0;
  endfunction

  function automatic void model_edge(logic [N-1:0] vin, bit rdy, bit r);
    int g;
    int merges;
    if (r) begin
      model_reset();
      return;
    end
    g = -1;
    if (!m_ov || rdy) begin
      for (int off = 1; off <= N; off++) begin
        int k;
        k = (m_ptr + off) % N;
        if (m_pend[k]) begin g = k; break; end
      end
      if (g >= 0) begin
        m_ov = 1'b1; m_oi = g; m_ptr = g; m_pend[g] = 1'b0;
      end else begin
        m_ov = 1'b0;
      end
    end
    merges = 0;
    for (int i = 0; i < N; i++) begin
      if (vin[i]) begin
        if (m_pend[i]) merges++;
        m_pend[i] = 1'b1;
      end
    end
    m_drop = (m_drop + merges > DMAX) ? DMAX : m_drop + merges;
  endfunction

  function automatic bit model_busy();
    bit b;
    b = m_ov;
    for (int i = 0; i < N; i++) b |= m_pend[i];
    return b;
  endfunction

  task automatic check(string tag, int got, int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, step model at the edge, compare #1 after.
  task automatic tick(logic [N-1:0] vin, bit rdy, bit r);
    rst           = r;
    bus.in        = vin;
    bus.out_ready = rdy;
    @(posedge clk);
    model_edge(vin, rdy, r);
    #1;
    check("out_valid", int'(bus.out_valid), int'(m_ov));
    check("out_idx",   int'(bus.out_idx),   m_oi);
    check("busy",      int'(bus.busy),      int'(model_busy()));
    check("drop_cnt",  int'(bus.drop_cnt),  m_drop);
  endtask

  function automatic logic [N-1:0] bit_of(int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [N-1:0] ones;
    ones = '1;
    rst = 1'b1; bus.in = '0; bus.out_ready = 1'b1;
    model_reset();

    // Reset with all inputs active
    tick(ones, 1'b1, 1'b1);
    tick(ones, 1'b1, 1'b1);
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_idx",   int'(bus.out_idx),   0);
    check("rst_busy",  int'(bus.busy),      0);
    check("rst_drop",  int'(bus.drop_cnt),  0);
    tick('0, 1'b1, 1'b0);
    check("post_rst_busy", int'(bus.busy), 0);

    // Single event
    tick(bit_of(3), 1'b1, 1'b0);
    check("single_not_yet", int'(bus.out_valid), 0);
    tick('0, 1'b1, 1'b0);
    check("single_valid", int'(bus.out_valid), 1);
    check("single_idx",   int'(bus.out_idx),   3);
    tick('0, 1'b1, 1'b0);
    check("single_done_valid", int'(bus.out_valid), 0);
    check("single_done_busy",  int'(bus.busy),      0);

    // Burst from fresh reset (ptr = N-1)
    tick('0, 1'b1, 1'b1);
    tick('0, 1'b1, 1'b0);
    tick(ones, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) begin
      tick('0, 1'b1, 1'b0);
      check("burst_idx", int'(bus.out_idx), i);
    end
    tick(bit_of(19) | bit_of(0), 1'b1, 1'b0);
    tick('0, 1'b1, 1'b0);
    check("wrap_first", int'(bus.out_idx), 0);
    tick('0, 1'b1, 1'b0);
    check("wrap_second", int'(bus.out_idx), 19);
    tick('0, 1'b1, 1'b0);

    // Backpressure
    tick(bit_of(5) | bit_of(2), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick('0, 1'b0, 1'b0);
      check("bp_hold_idx",   int'(bus.out_idx),   2);
      check("bp_hold_valid", int'(bus.out_valid), 1);
    end
    tick('0, 1'b1, 1'b0);
    check("bp_second", int'(bus.out_idx), 5);
    tick('0, 1'b1, 1'b0);
    check("bp_empty", int'(bus.out_valid), 0);
    tick(bit_of(4) | bit_of(6), 1'b1, 1'b0);
    tick('0, 1'b1, 1'b0);
    check("ptr5_next", int'(bus.out_idx), 6);
    tick('0, 1'b1, 1'b0);
    check("ptr5_after", int'(bus.out_idx), 4);
    tick('0, 1'b1, 1'b0);

    // Drop and simultaneity on source 7
    tick(bit_of(7), 1'b0, 1'b0);
    tick('0, 1'b0, 1'b0);
    check("drop_presented", int'(bus.out_idx), 7);
    tick(bit_of(7), 1'b0, 1'b0);
    check("drop_first_pulse", int'(bus.drop_cnt), 0);
    tick(bit_of(7), 1'b0, 1'b0);
    check("drop_second_pulse", int'(bus.drop_cnt), 1);
    tick(bit_of(7), 1'b1, 1'b0);
    check("simul_drop", int'(bus.drop_cnt), 1);
    check("simul_busy", int'(bus.busy), 1);
    check("simul_idx",  int'(bus.out_idx), 7);

    // Saturation
    for (int i = 0; i < 300; i++) tick(bit_of(7), 1'b0, 1'b0);
    check("sat_drop", int'(bus.drop_cnt), DMAX);
    check("sat_valid_before_rst", int'(bus.out_valid), 1);

    // Reset mid-operation
    tick(bit_of(7), 1'b0, 1'b1);
    check("mid_rst_valid", int'(bus.out_valid), 0);
    check("mid_rst_idx",   int'(bus.out_idx),   0);
    check("mid_rst_busy",  int'(bus.busy),      0);
    check("mid_rst_drop",  int'(bus.drop_cnt),  0);
    for (int i = 0; i < 3; i++) begin
      tick('0, 1'b1, 1'b0);
      check("no_stale", int'(bus.out_valid), 0);
    end

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] v;
      v = N'($urandom) & N'($urandom);
      if ($urandom_range(0, 3) == 0) v = '0;
      tick(v, ($urandom_range(0, 3) != 0), ($urandom_range(0, 149) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fanin_event_collector.md
# fanin_event_collector

Gathers single-cycle event pulses from N independent sources and serializes them onto one indexed output stream with valid/ready backpressure. Pending events are held per source, granted round-robin, and drops are counted. This is the fan-in counterpart of the fan-out buffer trees the optimizer produces, used wherever many leaf signals must be reported back through a single channel.

## Interface
- N, 20, number of event sources.
- IDXW, 5, width of out_idx; must satisfy 2^IDXW >= N.
- CNTW, 8, width of drop_cnt.

- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  N  event pulses; in[i]=1 for one cycle means one event from source i.
- out_valid  output  1  out_idx holds an event.
- out_idx  output  IDXW  source index (0..N-1) of the presented event.
- out_ready  input  1  consumer accepts the event when out_valid && out_ready.
- busy  output  1  |pending or out_valid (combinational from registers).
- drop_cnt  output  CNTW  saturating count of merged (lost) events.

## Operation
- State:
  - pending[N-1:0]
  - out register (out_valid, out_idx)
  - round-robin pointer ptr (IDXW bits)
  - drop_cnt
- Reset (rst=1 at an edge): pending=0, out_valid=0, out_idx=0, ptr=N-1, drop_cnt=0. Reset overrides all other activity, including mid-transfer; in is ignored that cycle.
- Output slot is free when !out_valid or (out_valid && out_ready).
- Grant:
  - When the slot is free and pending != 0, select the first set pending bit searching ptr+1, ptr+2, … with wrap from N-1 to 0 (ptr itself is searched last).
  - Load out_idx=k and out_valid=1; set ptr=k; clear pending[k].
- When the slot is free and pending == 0: out_valid <= 0; out_idx and ptr hold.
- When out_valid && !out_ready: out_valid, out_idx and ptr hold unchanged.
- Pending update per source i, same edge:
  - If in[i]=1 and pending[i] was 0, or pending[i] is being cleared by a grant this edge, then pending[i] <= 1 with no drop.
  - If in[i]=1 and pending[i] is 1 and not granted this edge, the event merges: pending[i] stays 1 and the drop counts.
- drop_cnt adds the number of merging sources in that cycle (0..N) and saturates at 2^CNTW-1, never wrapping.
- Events already in the out register are separate from pending. A source may have one event presented and one pending at the same time.

## Timing
- Latency: a pulse on in[i] sampled at edge E0 sets pending[i]; it is loaded into the out register at E1 at the earliest, so out_valid=1 one cycle after the pulse cycle.
- Throughput: one event per cycle while out_ready=1 and pending != 0.
- A grant and a new in[i] on the same source in the same edge are both kept: the current event goes to out, the new one to pending.
- out_idx and out_valid are registered. No combinational path runs from in or out_ready to any output except busy.
- Fairness: with K sources continuously pending, each is granted exactly once per K grants.

## Test plan
- Reset: drive in=all-ones, out_ready=1, rst=1 for 2 cycles. Required: out_valid=0, out_idx=0, busy=0, drop_cnt=0. The cycle after rst falls, busy=0.
- Single event: in[3] pulses at cycle 0 with out_ready=1. Required: out_valid=1 with out_idx=3 in cycle 1 only, then busy=0.
- Burst and wrap: all 20 bits pulse in one cycle with out_ready=1. Required: out_idx 0,1,…,19 on 20 consecutive cycles. Then pulse in[19] and in[0] together. Required: 0 first (ptr=19 wraps), then 19.
- Backpressure: pulse in[5] and in[2] with out_ready=0. Required: out_idx=2 holds while valid. After out_ready rises for 2 cycles, 2 is accepted then 5; ptr=5.
- Drop and simultaneity: with out_ready=0, in[7] is presented. Pulse in[7] twice more. Required: first pulse sets pending, second gives drop_cnt=1. Next, pulse in[7] in the same cycle its pending bit is granted. Required: drop_cnt unchanged, and pending[7] set again, shown by busy staying 1.
- Saturation and mid-operation reset: force 300 merges with CNTW=8. Required: drop_cnt=255. Assert rst while out_valid=1. Required: all state is at reset values the next cycle and no stale event appears.
